// File: rtl/mpmc10_rd_resp_wb.sv
// Wishbone read-response bridge: one outstanding read to the memory scheduler, byte-lane masked response, timeout to err_o.
// Latency: rd_valid_i to ack_o is one cycle; ack_o/err_o are held until stb_i is sampled low.
module mpmc10_rd_resp_wb #(
    parameter int WID = 16,
    parameter int TMO = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cyc_i,
    input  logic               stb_i,
    input  logic               we_i,
    input  logic [WID-1:0]     sel_i,
    input  logic [31:0]        adr_i,
    output logic               rd_req_o,
    output logic [31:0]        rd_adr_o,
    input  logic               rd_gnt_i,
    input  logic               rd_valid_i,
    input  logic [WID*8-1:0]   rd_dat_i,
    output logic               ack_o,
    output logic               err_o,
    output logic [WID*8-1:0]   dat_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ACK,
        S_ERR,
        S_DISCARD
    } state_t;

    localparam logic [31:0] ALIGN_MASK = ~(32'(WID) - 32'd1);
    localparam logic [7:0]  TMO_CNT    = 8'(TMO);

    state_t             state_q, state_d;
    logic [31:0]        rd_adr_q, rd_adr_d;
    logic [WID-1:0]     sel_q, sel_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [WID*8-1:0]   dat_q, dat_d;
    logic               rd_req_q, rd_req_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;

    logic [WID-1:0]     sel_eff;
    logic [WID*8-1:0]   dat_masked;
    logic               tmo_hit;

    // An all-zero byte select means a full-width read.
    always_comb begin
        sel_eff = (sel_q == '0) ? '1 : sel_q;
        for (int b = 0; b < WID; b++) begin
            dat_masked[b*8 +: 8] = sel_eff[b] ? rd_dat_i[b*8 +: 8] : 8'h00;
        end
    end

    assign tmo_hit = (cnt_q == TMO_CNT);

    always_comb begin
        state_d  = state_q;
        rd_adr_d = rd_adr_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        dat_d    = dat_q;
        unique case (state_q)
            S_IDLE: begin
                if (cyc_i && stb_i && !we_i) begin
                    state_d  = S_REQ;
                    rd_adr_d = adr_i & ALIGN_MASK;
                    sel_d    = sel_i;
                end
            end
            S_REQ: begin
                // A grant coinciding with the master dropping cyc still owes us a beat.
                if (rd_gnt_i) begin
                    cnt_d   = 8'd0;
                    state_d = cyc_i ? S_WAIT : S_DISCARD;
                end else if (!cyc_i) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (rd_valid_i) begin
                    if (cyc_i) begin
                        state_d = S_ACK;
                        dat_d   = dat_masked;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (tmo_hit) begin
                    if (cyc_i) begin
                        state_d = S_ERR;
                        dat_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = cyc_i ? S_WAIT : S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (rd_valid_i || tmo_hit) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_ACK, S_ERR: begin
                if (!stb_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        rd_req_d = (state_d == S_REQ);
        ack_d    = (state_d == S_ACK);
        err_d    = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rd_adr_q <= '0;
            sel_q    <= '0;
            cnt_q    <= '0;
            dat_q    <= '0;
            rd_req_q <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_adr_q <= rd_adr_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            dat_q    <= dat_d;
            rd_req_q <= rd_req_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    assign rd_req_o = rd_req_q;
    assign rd_adr_o = rd_adr_q;
    assign ack_o    = ack_q;
    assign err_o    = err_q;
    assign dat_o    = dat_q;

endmodule

// File: tb/tb_mpmc10_rd_resp_wb.sv
// Directed bench for mpmc10_rd_resp_wb with WID=16 and TMO=8.
module tb_mpmc10_rd_resp_wb;

    localparam int WID = 16;
    localparam int TMO = 8;

    logic               clk;
    logic               rst_n;
    logic               cyc_i;
    logic               stb_i;
    logic               we_i;
    logic [WID-1:0]     sel_i;
    logic [31:0]        adr_i;
    logic               rd_req_o;
    logic [31:0]        rd_adr_o;
    logic               rd_gnt_i;
    logic               rd_valid_i;
    logic [WID*8-1:0]   rd_dat_i;
    logic               ack_o;
    logic               err_o;
    logic [WID*8-1:0]   dat_o;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [127:0] DAT_AA   = {16{8'hAA}};
    localparam logic [127:0] DAT_SEQ  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] DAT_FULL = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] DAT_JUNK = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

    mpmc10_rd_resp_wb #(.WID(WID), .TMO(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cyc_i      (cyc_i),
        .stb_i      (stb_i),
        .we_i       (we_i),
        .sel_i      (sel_i),
        .adr_i      (adr_i),
        .rd_req_o   (rd_req_o),
        .rd_adr_o   (rd_adr_o),
        .rd_gnt_i   (rd_gnt_i),
        .rd_valid_i (rd_valid_i),
        .rd_dat_i   (rd_dat_i),
        .ack_o      (ack_o),
        .err_o      (err_o),
        .dat_o      (dat_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_read(input logic [31:0] adr, input logic [15:0] sel);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = adr; sel_i = sel;
        tick();
    endtask

    task automatic end_cycle();
        cyc_i = 1'b0; stb_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cyc_i = 0; stb_i = 0; we_i = 0; sel_i = '0; adr_i = '0;
        rd_gnt_i = 0; rd_valid_i = 0; rd_dat_i = '0;
        repeat (2) tick();
        n_cmp++; if ({rd_req_o, ack_o, err_o} !== 3'b000) begin n_bad++; $display("FAIL reset_ctl got %b want 000", {rd_req_o, ack_o, err_o}); end
        n_cmp++; if (rd_adr_o !== 32'h0) begin n_bad++; $display("FAIL reset_adr got %h want 0", rd_adr_o); end
        n_cmp++; if (dat_o !== '0) begin n_bad++; $display("FAIL reset_dat got %h want 0", dat_o); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (ack_o !== 1'b0) begin n_bad++; $display("FAIL reset_release_ack got %b want 0", ack_o); end
    endtask

    task automatic test_basic_read();
        start_read(32'h0000_1234, 16'h000F);
        n_cmp++; if (rd_req_o !== 1'b1) begin n_bad++; $display("FAIL basic_req got %b want 1", rd_req_o); end
        n_cmp++; if (rd_adr_o !== 32'h0000_1230) begin n_bad++; $display("FAIL basic_adr got %h want 00001230", rd_adr_o); end
        rd_gnt_i = 1'b1;
        tick();
        rd_gnt_i = 1'b0;
        n_cmp++; if (rd_req_o !== 1'b0) begin n_bad++; $display("FAIL basic_req_drop got %b want 0", rd_req_o); end
        tick(); tick();
        rd_valid_i = 1'b1; rd_dat_i = DAT_AA;
        n_cmp++; if (ack_o !== 1'b0) begin n_bad++; $display("FAIL basic_ack_early got %b want 0", ack_o); end
        tick();
        rd_valid_i = 1'b0; rd_dat_i = DAT_JUNK;
        n_cmp++; if (ack_o !== 1'b1) begin n_bad++; $display("FAIL basic_ack got %b want 1", ack_o); end
        n_cmp++; if (dat_o !== 128'h0000_0000_0000_0000_0000_0000_AAAA_AAAA) begin n_bad++; $display("FAIL basic_dat got %h want low 4 bytes AA", dat_o); end
        tick();
        n_cmp++; if (ack_o !== 1'b1) begin n_bad++; $display("FAIL basic_ack_hold got %b want 1", ack_o); end
        end_cycle();
        n_cmp++; if (ack_o !== 1'b0) begin n_bad++; $display("FAIL basic_ack_release got %b want 0", ack_o); end
    endtask

    task automatic test_timeout();
        int ack_seen;
        ack_seen = 0;
        start_read(32'h0000_0040, 16'h0000);
        rd_gnt_i = 1'b1;
        tick();
        rd_gnt_i = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            tick();
            if (ack_o === 1'b1) ack_seen++;
        end
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL tmo_err_early got %b want 0", err_o); end
        tick();
        n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL tmo_err got %b want 1", err_o); end
        n_cmp++; if (dat_o !== '0) begin n_bad++; $display("FAIL tmo_dat got %h want 0", dat_o); end
        if (ack_o === 1'b1) ack_seen++;
        n_cmp++; if (ack_seen != 0) begin n_bad++; $display("FAIL tmo_no_ack got %0d ack cycles want 0", ack_seen); end
        end_cycle();
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL tmo_err_release got %b want 0", err_o); end

        start_read(32'h0000_0050, 16'h0000);
        rd_gnt_i = 1'b1;
        tick();
        rd_gnt_i = 1'b0;
        repeat (TMO) tick();
        rd_valid_i = 1'b1; rd_dat_i = DAT_FULL;
        tick();
        rd_valid_i = 1'b0;
        n_cmp++; if ({ack_o, err_o} !== 2'b10) begin n_bad++; $display("FAIL tmo_race_ack got %b want 10", {ack_o, err_o}); end
        n_cmp++; if (dat_o !== DAT_FULL) begin n_bad++; $display("FAIL tmo_race_dat got %h want %h", dat_o, DAT_FULL); end
        end_cycle();
    endtask

    task automatic test_abort();
        int bad;
        bad = 0;
        start_read(32'h0000_0100, 16'hFFFF);
        rd_gnt_i = 1'b1;
        tick();
        rd_gnt_i = 1'b0;
        tick();
        cyc_i = 1'b0; stb_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ack_o !== 1'b0 || err_o !== 1'b0 || rd_req_o !== 1'b0) bad++;
        end
        rd_valid_i = 1'b1; rd_dat_i = DAT_JUNK;
        tick();
        rd_valid_i = 1'b0;
        tick();
        if (ack_o !== 1'b0 || err_o !== 1'b0) bad++;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL abort_quiet got %0d bad cycles want 0", bad); end
        n_cmp++; if (dat_o !== DAT_FULL) begin n_bad++; $display("FAIL abort_dat_hold got %h want %h", dat_o, DAT_FULL); end

        start_read(32'h0000_2005, 16'h8001);
        n_cmp++; if (rd_adr_o !== 32'h0000_2000) begin n_bad++; $display("FAIL abort_next_adr got %h want 00002000", rd_adr_o); end
        rd_gnt_i = 1'b1;
        tick();
        rd_gnt_i = 1'b0;
        rd_valid_i = 1'b1; rd_dat_i = DAT_SEQ;
        tick();
        rd_valid_i = 1'b0;
        n_cmp++; if (ack_o !== 1'b1) begin n_bad++; $display("FAIL abort_next_ack got %b want 1", ack_o); end
        n_cmp++; if (dat_o !== 128'h0F00_0000_0000_0000_0000_0000_0000_0000) begin n_bad++; $display("FAIL abort_next_dat got %h want byte0/15 only", dat_o); end
        end_cycle();
    endtask

    task automatic test_req_abort();
        start_read(32'h0000_0200, 16'hFFFF);
        cyc_i = 1'b0; stb_i = 1'b0;
        tick();
        n_cmp++; if (rd_req_o !== 1'b0) begin n_bad++; $display("FAIL req_abort got %b want 0", rd_req_o); end
        rd_gnt_i = 1'b1;
        tick();
        rd_gnt_i = 1'b0;
        n_cmp++; if (rd_req_o !== 1'b0) begin n_bad++; $display("FAIL req_abort_stay got %b want 0", rd_req_o); end
    endtask

    task automatic test_write_ignored();
        int bad;
        bad = 0;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 32'h0000_4444; sel_i = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rd_req_o !== 1'b0 || ack_o !== 1'b0) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL write_ignored got %0d bad cycles want 0", bad); end
        we_i = 1'b0;
        end_cycle();
    endtask

    task automatic test_reset_mid_ack();
        start_read(32'h0000_0300, 16'hFFFF);
        rd_gnt_i = 1'b1;
        tick();
        rd_gnt_i = 1'b0;
        rd_valid_i = 1'b1; rd_dat_i = DAT_FULL;
        tick();
        rd_valid_i = 1'b0;
        n_cmp++; if (ack_o !== 1'b1) begin n_bad++; $display("FAIL rst_pre_ack got %b want 1", ack_o); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({rd_req_o, ack_o, err_o} !== 3'b000 || rd_adr_o !== 32'h0 || dat_o !== '0) begin
            n_bad++; $display("FAIL rst_async got ctl=%b adr=%h dat=%h want all 0", {rd_req_o, ack_o, err_o}, rd_adr_o, dat_o);
        end
        cyc_i = 1'b0; stb_i = 1'b0;
        tick();
        rst_n = 1'b1;
        rd_valid_i = 1'b1; rd_dat_i = DAT_JUNK;
        tick();
        rd_valid_i = 1'b0;
        tick();
        n_cmp++; if (ack_o !== 1'b0 || dat_o !== '0) begin n_bad++; $display("FAIL rst_late_valid got ack=%b dat=%h want 0/0", ack_o, dat_o); end

        start_read(32'h0000_3333, 16'h00F0);
        n_cmp++; if (rd_adr_o !== 32'h0000_3330) begin n_bad++; $display("FAIL rst_next_adr got %h want 00003330", rd_adr_o); end
        rd_gnt_i = 1'b1;
        tick();
        rd_gnt_i = 1'b0;
        rd_valid_i = 1'b1; rd_dat_i = DAT_SEQ;
        n_cmp++; if (ack_o !== 1'b0) begin n_bad++; $display("FAIL rst_next_ack_early got %b want 0", ack_o); end
        tick();
        rd_valid_i = 1'b0;
        n_cmp++; if ({ack_o, err_o} !== 2'b10) begin n_bad++; $display("FAIL rst_next_ack got %b want 10", {ack_o, err_o}); end
        n_cmp++; if (dat_o !== 128'h0000_0000_0000_0000_0706_0504_0000_0000) begin n_bad++; $display("FAIL rst_next_dat got %h want bytes 4..7", dat_o); end
        end_cycle();
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_timeout();
        test_abort();
        test_req_abort();
        test_write_ignored();
        test_reset_mid_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
